switch_allocator: RTL and testbench
===================================

SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 The block SHALL have no parameters; port count is fixed at 5 with index/code 0=L, 1=N, 2=E, 3=S, 4=W, the same codes the crossbar select inputs use.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  5  bit i: input port i holds a valid flit.
REQ-005 req_head  input  5  bit i: flit at input i is a packet head.
REQ-006 req_tail  input  5  bit i: flit at input i is a packet tail (head+tail = single-flit packet).
REQ-007 req_dest  input  15  bits [3i+2:3i]: requested output code (0-4) of input i.
REQ-008 out_ready  input  5  bit o: downstream of output o can accept a flit this cycle.
REQ-009 sel  output  15  bits [3o+2:3o]: crossbar select for output o; 3'd7 = idle.
REQ-010 grant  output  5  bit i: flit at input i is transferred this cycle (input pops it).

Function
REQ-011 Each output o SHALL hold a registered state IDLE or LOCKED plus a 3-bit owner and a 3-bit round-robin pointer ptr[o] (range 0-4).
REQ-012 A request of input i to output o SHALL exist when req_valid[i]=1 and req_dest[i]=o; req_dest values 5-7 SHALL be ignored (no request, no grant).
REQ-013 In IDLE, output o SHALL arbitrate among inputs with a request to o and req_head=1, picking the first such input at or after ptr[o] cyclically (ptr, ptr+1, ... mod 5).
REQ-014 A winner SHALL move o to LOCKED with owner=winner at the next edge; arbitration latency is exactly 1 cycle, and no grant is issued in the arbitration cycle.
REQ-015 Requests with req_head=0 SHALL never win arbitration.
REQ-016 sel[o] SHALL equal owner while LOCKED and 3'd7 while IDLE, driven purely from registered state.
REQ-017 grant[i] SHALL be combinational: 1 iff some output o is LOCKED with owner=i, req_valid[i]=1, req_dest[i]=o, out_ready[o]=1.
REQ-018 When grant[i]=1 and req_tail[i]=1, o SHALL return to IDLE at the next edge and ptr[o] SHALL become (owner+1) mod 5.
REQ-019 ptr[o] SHALL change only on release (REQ-018).
REQ-020 A released output SHALL arbitrate again in the cycle after release, so one idle cycle separates back-to-back packets on the same output.
REQ-021 out_ready[o]=0 or req_valid[owner]=0 while LOCKED SHALL hold the lock, with no grant and no state change.
REQ-022 A flit at input i whose req_dest differs from its locked output SHALL not be granted.
REQ-023 Input == output (e.g. L->L loopback) SHALL be a legal request.
REQ-024 The five outputs SHALL arbitrate independently in the same cycle, so up to five grants can occur per cycle.
REQ-025 At most one bit of grant SHALL be set per locked output, and no input SHALL own two outputs.

Reset
REQ-026 rst_n=0 SHALL immediately force all outputs IDLE, owner=0, ptr=0, sel=all 3'd7, and grant=0, regardless of clk.
REQ-027 Reset asserted mid-packet SHALL drop all locks; after deassertion, allocation restarts from ptr=0 and needs a new head flit.

Verification
REQ-028 Reset: rst_n=0 mid-packet with clk stopped -> sel=15'h7FFF, grant=0 within the same time step.
REQ-029 Single-flit: L head+tail to E, out_ready=all 1 -> cycle 1 sel_E=7; cycle 2 sel_E=0, grant=5'b00001; cycle 3 sel_E=7, ptr_E=1.
REQ-030 Contention: N, S, W heads to L simultaneously, 2-flit packets, ptr_L=0 -> owners in order N(1), S(3), W(4), each ownership separated by 1 idle cycle.
REQ-031 Backpressure: E locked to W, out_ready[2]=0 for 3 cycles mid-packet -> grant[4]=0, sel_E stays 4, and the packet completes once ready returns.
REQ-032 Parallel: L->N, N->E, E->S, S->W, W->L all single-flit -> all five sel locked next cycle, grant=5'b11111 in one cycle.
REQ-033 Illegal: req_dest=6 on input S, or body flit (head=0) to an idle output -> no lock, grant[3]=0, sel unchanged.

Source files
------------

// File: rtl/switch_allocator_if.sv
// Request/grant bundle between the five input buffers, the five output
// links and the switch allocator. The allocator side is the slave; whoever
// drives the flit requests and downstream readiness is the master.
interface switch_allocator_if;
  logic [4:0]  req_valid;
  logic [4:0]  req_head;
  logic [4:0]  req_tail;
  logic [14:0] req_dest;
  logic [4:0]  out_ready;
  logic [14:0] sel;
  logic [4:0]  grant;

  modport master (
    output req_valid,
    output req_head,
    output req_tail,
    output req_dest,
    output out_ready,
    input  sel,
    input  grant
  );

  modport slave (
    input  req_valid,
    input  req_head,
    input  req_tail,
    input  req_dest,
    input  out_ready,
    output sel,
    output grant
  );
endinterface

// File: rtl/switch_allocator.sv
// Five-port wormhole switch allocator (codes 0=L 1=N 2=E 3=S 4=W).
// Each output is held by one input from head flit to tail flit. Idle outputs
// pick a new head flit round-robin, starting just past the previous owner.
// Crossbar selects come straight from registered state; grants are
// combinational so an input can pop its flit in the same cycle.
module switch_allocator (
  input  logic            clk,
  input  logic            rst_n,
  switch_allocator_if.slave bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } out_state_e;

  localparam logic [2:0] SEL_IDLE = 3'd7;

  out_state_e state_q [5];
  out_state_e state_d [5];
  logic [2:0] owner_q [5];
  logic [2:0] owner_d [5];
  logic [2:0] ptr_q   [5];
  logic [2:0] ptr_d   [5];

  logic [14:0] sel_c;
  logic [4:0]  grant_c;
  logic [4:0]  out_fire;
  logic [4:0]  owned;

  // Cyclic successor within the five port codes.
  function automatic logic [2:0] inc_mod5(input logic [2:0] v);
    return (v >= 3'd4) ? 3'd0 : v + 3'd1;
  endfunction

  // Per-output state, owner and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < 5; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= 3'd0;
        ptr_q[o]   <= 3'd0;
      end
    end else begin
      for (int o = 0; o < 5; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
    end
  end

  // Next state: idle outputs arbitrate among heads, locked outputs release on a granted tail.
  always_comb begin : next_state
    logic       found;
    logic [2:0] cand;
    found = 1'b0;
    cand  = 3'd0;
    for (int o = 0; o < 5; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
    end
    for (int o = 0; o < 5; o++) begin
      if (state_q[o] == IDLE) begin
        found = 1'b0;
        cand  = ptr_q[o];
        for (int k = 0; k < 5; k++) begin
          if (!found && bus.req_valid[cand] && bus.req_head[cand] &&
              !owned[cand] && (bus.req_dest[3*cand +: 3] == 3'(o))) begin
            found      = 1'b1;
            owner_d[o] = cand;
          end
          cand = inc_mod5(cand);
        end
        if (found) begin
          state_d[o] = LOCKED;
        end
      end else if (out_fire[o] && bus.req_tail[owner_q[o]]) begin
        state_d[o] = IDLE;
        ptr_d[o]   = inc_mod5(owner_q[o]);
      end
    end
  end

  // Outputs: selects from registered ownership, grants where the owner's flit can move.
  always_comb begin
    sel_c    = {5{SEL_IDLE}};
    grant_c  = 5'd0;
    out_fire = 5'd0;
    owned    = 5'd0;
    for (int o = 0; o < 5; o++) begin
      if (state_q[o] == LOCKED) begin
        sel_c[3*o +: 3]    = owner_q[o];
        owned[owner_q[o]]  = 1'b1;
        if (bus.req_valid[owner_q[o]] && bus.out_ready[o] &&
            (bus.req_dest[3*owner_q[o] +: 3] == 3'(o))) begin
          out_fire[o]         = 1'b1;
          grant_c[owner_q[o]] = 1'b1;
        end
      end
    end
  end

  assign bus.sel   = sel_c;
  assign bus.grant = grant_c;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed, table-driven bench for the five-port switch allocator.
module tb_switch_allocator;

  typedef struct {
    logic [4:0]  valid;
    logic [4:0]  head;
    logic [4:0]  tail;
    logic [14:0] dest;
    logic [4:0]  ready;
    logic [14:0] expSel;
    logic [4:0]  expGrant;
  } vec_t;

  localparam logic [14:0] IDLE_SEL = 15'h7FFF;
  localparam logic [4:0]  ALL      = 5'b11111;

  logic clk   = 1'b0;
  logic clkEn = 1'b1;
  logic rst_n;

  int vecCount  = 0;
  int missCount = 0;
  vec_t vecs[$];

  switch_allocator_if bus ();

  switch_allocator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Free-running clock that can be parked low to test reset with no edges.
  always #5 if (clkEn) clk = ~clk;

  function automatic logic [14:0] pack5(input int a0, input int a1, input int a2,
                                        input int a3, input int a4);
    return {3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  function automatic vec_t mkVec(input logic [4:0] valid, input logic [4:0] head,
                                 input logic [4:0] tail, input logic [14:0] dest,
                                 input logic [4:0] ready, input logic [14:0] expSel,
                                 input logic [4:0] expGrant);
    vec_t v;
    v.valid    = valid;
    v.head     = head;
    v.tail     = tail;
    v.dest     = dest;
    v.ready    = ready;
    v.expSel   = expSel;
    v.expGrant = expGrant;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [14:0] expSel,
                             input logic [4:0] expGrant);
    vecCount++;
    if (bus.sel !== expSel) begin
      missCount++;
      $display("[TB] FAIL %s sel: got %h expected %h", name, bus.sel, expSel);
    end
    vecCount++;
    if (bus.grant !== expGrant) begin
      missCount++;
      $display("[TB] FAIL %s grant: got %b expected %b", name, bus.grant, expGrant);
    end
  endtask

  task automatic applyStimulus(input string name, input vec_t v);
    @(negedge clk);
    bus.req_valid = v.valid;
    bus.req_head  = v.head;
    bus.req_tail  = v.tail;
    bus.req_dest  = v.dest;
    bus.out_ready = v.ready;
    #1;
    checkOutput(name, v.expSel, v.expGrant);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [14:0] dLE;
    logic [14:0] dCont;
    logic [14:0] dWE;
    logic [14:0] sE4;

    dLE   = pack5(2, 7, 7, 7, 7);
    dCont = pack5(7, 0, 7, 0, 0);
    dWE   = pack5(7, 7, 7, 7, 2);
    sE4   = pack5(7, 7, 4, 7, 7);

    // single-flit L->E, then E pointer advanced past L so N beats L
    vecs.push_back(mkVec(5'b00001, 5'b00001, 5'b00001, dLE, ALL, IDLE_SEL, 5'b00000));
    vecs.push_back(mkVec(5'b00001, 5'b00001, 5'b00001, dLE, ALL, pack5(7,7,0,7,7), 5'b00001));
    vecs.push_back(mkVec(5'b00000, 5'b00000, 5'b00000, dLE, ALL, IDLE_SEL, 5'b00000));
    vecs.push_back(mkVec(5'b00011, 5'b00011, 5'b00011, pack5(2,2,7,7,7), ALL, IDLE_SEL, 5'b00000));
    vecs.push_back(mkVec(5'b00011, 5'b00011, 5'b00011, pack5(2,2,7,7,7), ALL, pack5(7,7,1,7,7), 5'b00010));
    vecs.push_back(mkVec(5'b00001, 5'b00001, 5'b00001, dLE, ALL, IDLE_SEL, 5'b00000));
    vecs.push_back(mkVec(5'b00001, 5'b00001, 5'b00001, dLE, ALL, pack5(7,7,0,7,7), 5'b00001));
    vecs.push_back(mkVec(5'b00000, 5'b00000, 5'b00000, dLE, ALL, IDLE_SEL, 5'b00000));

    // N, S, W two-flit packets contending for L
    vecs.push_back(mkVec(5'b11010, 5'b11010, 5'b00000, dCont, ALL, IDLE_SEL, 5'b00000));
    vecs.push_back(mkVec(5'b11010, 5'b11010, 5'b00000, dCont, ALL, pack5(1,7,7,7,7), 5'b00010));
    vecs.push_back(mkVec(5'b11010, 5'b11000, 5'b00010, dCont, ALL, pack5(1,7,7,7,7), 5'b00010));
    vecs.push_back(mkVec(5'b11000, 5'b11000, 5'b00000, dCont, ALL, IDLE_SEL, 5'b00000));
    vecs.push_back(mkVec(5'b11000, 5'b11000, 5'b00000, dCont, ALL, pack5(3,7,7,7,7), 5'b01000));
    vecs.push_back(mkVec(5'b11000, 5'b10000, 5'b01000, dCont, ALL, pack5(3,7,7,7,7), 5'b01000));
    vecs.push_back(mkVec(5'b10000, 5'b10000, 5'b00000, dCont, ALL, IDLE_SEL, 5'b00000));
    vecs.push_back(mkVec(5'b10000, 5'b10000, 5'b00000, dCont, ALL, pack5(4,7,7,7,7), 5'b10000));
    vecs.push_back(mkVec(5'b10000, 5'b00000, 5'b10000, dCont, ALL, pack5(4,7,7,7,7), 5'b10000));
    vecs.push_back(mkVec(5'b00000, 5'b00000, 5'b00000, dCont, ALL, IDLE_SEL, 5'b00000));

    // W->E with backpressure, an empty cycle and a misdirected body flit
    vecs.push_back(mkVec(5'b10000, 5'b10000, 5'b00000, dWE, ALL, IDLE_SEL, 5'b00000));
    vecs.push_back(mkVec(5'b10000, 5'b10000, 5'b00000, dWE, ALL, sE4, 5'b10000));
    vecs.push_back(mkVec(5'b10000, 5'b00000, 5'b00000, dWE, 5'b11011, sE4, 5'b00000));
    vecs.push_back(mkVec(5'b10000, 5'b00000, 5'b00000, dWE, 5'b11011, sE4, 5'b00000));
    vecs.push_back(mkVec(5'b10000, 5'b00000, 5'b00000, dWE, 5'b11011, sE4, 5'b00000));
    vecs.push_back(mkVec(5'b00000, 5'b00000, 5'b00000, dWE, ALL, sE4, 5'b00000));
    vecs.push_back(mkVec(5'b10000, 5'b00000, 5'b00000, pack5(7,7,7,7,3), ALL, sE4, 5'b00000));
    vecs.push_back(mkVec(5'b10000, 5'b00000, 5'b00000, dWE, ALL, sE4, 5'b10000));
    vecs.push_back(mkVec(5'b10000, 5'b00000, 5'b10000, dWE, ALL, sE4, 5'b10000));
    vecs.push_back(mkVec(5'b00000, 5'b00000, 5'b00000, dWE, ALL, IDLE_SEL, 5'b00000));

    // all five outputs locked and granted in parallel
    vecs.push_back(mkVec(5'b11111, 5'b11111, 5'b11111, pack5(1,2,3,4,0), ALL, IDLE_SEL, 5'b00000));
    vecs.push_back(mkVec(5'b11111, 5'b11111, 5'b11111, pack5(1,2,3,4,0), ALL, pack5(4,0,1,2,3), 5'b11111));
    vecs.push_back(mkVec(5'b00000, 5'b00000, 5'b00000, pack5(1,2,3,4,0), ALL, IDLE_SEL, 5'b00000));

    // L->L loopback
    vecs.push_back(mkVec(5'b00001, 5'b00001, 5'b00001, pack5(0,7,7,7,7), ALL, IDLE_SEL, 5'b00000));
    vecs.push_back(mkVec(5'b00001, 5'b00001, 5'b00001, pack5(0,7,7,7,7), ALL, pack5(0,7,7,7,7), 5'b00001));
    vecs.push_back(mkVec(5'b00000, 5'b00000, 5'b00000, pack5(0,7,7,7,7), ALL, IDLE_SEL, 5'b00000));

    // illegal destination and headless body flit never lock
    vecs.push_back(mkVec(5'b01000, 5'b01000, 5'b01000, pack5(7,7,7,6,7), ALL, IDLE_SEL, 5'b00000));
    vecs.push_back(mkVec(5'b01000, 5'b01000, 5'b01000, pack5(7,7,7,6,7), ALL, IDLE_SEL, 5'b00000));
    vecs.push_back(mkVec(5'b01000, 5'b00000, 5'b00000, pack5(7,7,7,1,7), ALL, IDLE_SEL, 5'b00000));
    vecs.push_back(mkVec(5'b01000, 5'b00000, 5'b00000, pack5(7,7,7,1,7), ALL, IDLE_SEL, 5'b00000));
    vecs.push_back(mkVec(5'b00000, 5'b00000, 5'b00000, pack5(7,7,7,7,7), ALL, IDLE_SEL, 5'b00000));

    // reset state with requests already pending
    rst_n         = 1'b0;
    bus.req_valid = 5'b11111;
    bus.req_head  = 5'b11111;
    bus.req_tail  = 5'b11111;
    bus.req_dest  = pack5(0, 0, 0, 0, 0);
    bus.out_ready = ALL;
    #1;
    checkOutput("reset", IDLE_SEL, 5'b00000);
    bus.req_valid = 5'b00000;
    bus.req_head  = 5'b00000;
    bus.req_tail  = 5'b00000;
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i]);
    end

    // move L pointer to 2 via a N->L packet, then lock L->E mid-packet
    applyStimulus("ptrL_arb",  mkVec(5'b00010, 5'b00010, 5'b00010, pack5(7,0,7,7,7), ALL, IDLE_SEL, 5'b00000));
    applyStimulus("ptrL_gnt",  mkVec(5'b00010, 5'b00010, 5'b00010, pack5(7,0,7,7,7), ALL, pack5(1,7,7,7,7), 5'b00010));
    applyStimulus("midpk_arb", mkVec(5'b00001, 5'b00001, 5'b00000, dLE, ALL, IDLE_SEL, 5'b00000));
    applyStimulus("midpk_gnt", mkVec(5'b00001, 5'b00000, 5'b00000, dLE, ALL, pack5(7,7,0,7,7), 5'b00001));

    // asynchronous reset with the clock parked
    clkEn = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", IDLE_SEL, 5'b00000);
    #1;
    rst_n = 1'b1;
    clkEn = 1'b1;

    // leftover body flit cannot reacquire; pointers restart at 0 so N beats S
    applyStimulus("post_body0", mkVec(5'b00001, 5'b00000, 5'b00000, dLE, ALL, IDLE_SEL, 5'b00000));
    applyStimulus("post_body1", mkVec(5'b00001, 5'b00000, 5'b00000, dLE, ALL, IDLE_SEL, 5'b00000));
    applyStimulus("post_arb",   mkVec(5'b01010, 5'b01010, 5'b01010, pack5(7,0,7,0,7), ALL, IDLE_SEL, 5'b00000));
    applyStimulus("post_gntN",  mkVec(5'b01010, 5'b01010, 5'b01010, pack5(7,0,7,0,7), ALL, pack5(1,7,7,7,7), 5'b00010));
    applyStimulus("post_gap",   mkVec(5'b01000, 5'b01000, 5'b01000, pack5(7,0,7,0,7), ALL, IDLE_SEL, 5'b00000));
    applyStimulus("post_gntS",  mkVec(5'b01000, 5'b01000, 5'b01000, pack5(7,0,7,0,7), ALL, pack5(3,7,7,7,7), 5'b01000));
    applyStimulus("post_idle",  mkVec(5'b00000, 5'b00000, 5'b00000, pack5(7,0,7,0,7), ALL, IDLE_SEL, 5'b00000));

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
